uart_rx_fifo: RTL and testbench

- Byte buffer directly downstream of the UART receiver.
- Captures each completed receive frame and stores it in a circular buffer; a host-side consumer drains it with a read-enable/valid handshake.
- A sticky overflow flag reports bytes dropped because the buffer was full.
- Sits between the receiver's rx_data/rx_int outputs and the application logic that consumes received bytes.

---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 80 ++++++++
 tb/tb_uart_rx_fifo.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer bundle for uart_rx_fifo: frame capture inputs, pop handshake and status.
// The master side drives frames and pops; the slave side is the buffer.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                rx_int;
    logic                rd_en;
    logic                ovf_clr;
    logic [7:0]          rd_data;
    logic                rd_valid;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    modport master (
        output rx_data, rx_int, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, rx_int, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte buffer behind the UART receiver; pushes on rx_int falling edge, rd_en->rd_valid is 1 cycle.
// No backpressure to the receiver: a frame arriving while full is dropped and sets sticky overflow.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_rx_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  rx_int_d_q;

    logic empty, full, push_req, pop_ok, push_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign push_req = rx_int_d_q & ~bus.rx_int;
    assign pop_ok   = bus.rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push_ok  = push_req & (~full | pop_ok);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
        if (bus.ovf_clr) ovf_d = 1'b0;
        if (push_req && full && !pop_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_int_d_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_int_d_q <= bus.rx_int;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: expected bytes queued at stimulus time, checked by a negedge monitor.
module tb_uart_rx_fifo;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    logic [7:0] exp_q [$];

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Every rd_valid pulse must match the oldest byte still owed to the consumer.
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_rd_valid: got rd_data %0h, expected no pop", bus.rd_data);
            end else begin
                chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit with_rd, input bit with_clr,
                              input bit accepted);
        bus.rx_int = 1'b1;
        tick();
        tick();
        bus.rx_int  = 1'b0;
        bus.rx_data = b;
        bus.rd_en   = with_rd;
        bus.ovf_clr = with_clr;
        if (accepted) exp_q.push_back(b);
        tick();
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) send_frame(base + 8'(i), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) pop_one();
        tick();
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst_n       = 1'b0;
        bus.rx_int  = 1'b1;
        bus.rx_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_rd_data", int'(bus.rd_data), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_overflow", int'(bus.overflow), 0);

        // 1: release reset with rx_int high, then one falling edge
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t1_no_spurious", int'(bus.count), 0);
        bus.rx_int  = 1'b0;
        bus.rx_data = 8'h00;
        exp_q.push_back(8'h00);
        tick();
        repeat (3) tick();
        chk("t1_count", int'(bus.count), 1);
        chk("t1_empty", int'(bus.empty), 0);
        drain(1);
        chk("t1_empty_after", int'(bus.empty), 1);

        // 2: single frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("t2_count", int'(bus.count), 1);
        pop_one();
        chk("t2_rd_valid", int'(bus.rd_valid), 1);
        chk("t2_count_after", int'(bus.count), 0);
        chk("t2_empty", int'(bus.empty), 1);
        tick();

        // 3: fill, drain, wrap
        fill(8'h00);
        chk("t3_full", int'(bus.full), 1);
        chk("t3_count", int'(bus.count), 16);
        drain(16);
        chk("t3_empty", int'(bus.empty), 1);
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        chk("t3_count5", int'(bus.count), 5);
        drain(5);

        // 4: overflow while full
        fill(8'h00);
        send_frame(8'hEE, 1'b0, 1'b0, 1'b0);
        chk("t4_overflow", int'(bus.overflow), 1);
        chk("t4_count", int'(bus.count), 16);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t4_ovf_clr", int'(bus.overflow), 0);
        drain(16);

        // 5: full with simultaneous push and pop
        fill(8'h00);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        chk("t5_overflow", int'(bus.overflow), 0);
        chk("t5_count", int'(bus.count), 16);
        drain(16);
        chk("t5_empty", int'(bus.empty), 1);

        // 6: empty corner cases
        pop_one();
        chk("t6_rd_valid_empty", int'(bus.rd_valid), 0);
        chk("t6_count_empty", int'(bus.count), 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        chk("t6_count_pushpop", int'(bus.count), 1);
        chk("t6_no_valid", int'(bus.rd_valid), 0);
        drain(1);
        fill(8'h40);
        send_frame(8'h99, 1'b0, 1'b1, 1'b0);
        chk("t6_set_beats_clr", int'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        drain(16);

        // reset mid-operation discards stored bytes
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5B, 1'b0, 1'b0, 1'b0);
        chk("mid_count_before", int'(bus.count), 2);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_count", int'(bus.count), 0);
        chk("mid_rst_empty", int'(bus.empty), 1);
        rst_n = 1'b1;
        pop_one();
        tick();
        chk("all_bytes_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
